// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arb (with alu_share_pkg and alu)
// Purpose  : Round-robin arbiter that shares one combinational ALU among
//            NUM_REQ requesters. It accepts at most one op per cycle and
//            returns each result through a single-entry response buffer
//            using a valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Opcode encoding shared by the ALU, the arbiter and anything that issues ops.
// Codes above ALU_JALR are illegal.
// ----------------------------------------------------------------------------
package alu_share_pkg;
    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_JALR = 4'd10;
endpackage

// ============================================================================
// Module   : alu
// Purpose  : Purely combinational integer ALU, WIDTH bits with wrap-around.
//            Shifts use the low log2(WIDTH) bits of b. Illegal codes
//            produce zero.
// Revision : 1.0  initial release
// ============================================================================
module alu
    import alu_share_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int OP_WIDTH = ALU_OP_W
) (
    input  logic [WIDTH-1:0]    a_i,
    input  logic [WIDTH-1:0]    b_i,
    input  logic [OP_WIDTH-1:0] op_i,
    output logic [WIDTH-1:0]    res_o,
    output logic                zero_o
);

    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [SHW-1:0] w_shamt;

    assign w_shamt = b_i[SHW-1:0];

    // Decode the opcode and compute the result.
    always_comb begin
        res_o = '0;
        case (op_i)
            OP_WIDTH'(ALU_ADD):  res_o = a_i + b_i;
            OP_WIDTH'(ALU_SUB):  res_o = a_i - b_i;
            OP_WIDTH'(ALU_SLL):  res_o = a_i << w_shamt;
            OP_WIDTH'(ALU_SLT):  res_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_WIDTH'(ALU_SLTU): res_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
            OP_WIDTH'(ALU_XOR):  res_o = a_i ^ b_i;
            OP_WIDTH'(ALU_SRL):  res_o = a_i >> w_shamt;
            OP_WIDTH'(ALU_SRA):  res_o = WIDTH'($signed(a_i) >>> w_shamt);
            OP_WIDTH'(ALU_OR):   res_o = a_i | b_i;
            OP_WIDTH'(ALU_AND):  res_o = a_i & b_i;
            // The jump target always has bit 0 cleared.
            OP_WIDTH'(ALU_JALR): res_o = (a_i + b_i) & ~WIDTH'(1);
            default:             res_o = '0;
        endcase
    end

    assign zero_o = (res_o == '0);

endmodule

// ============================================================================
// Module   : alu_share_arb
// Purpose  : Round-robin grant, operand mux into the shared ALU, and a
//            single-entry response buffer with per-requester handshake.
// Revision : 1.0  initial release
// ============================================================================
module alu_share_arb
    import alu_share_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int WIDTH    = 64,
    parameter int OP_WIDTH = ALU_OP_W,
    parameter int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0]     req_a_i,
    input  logic [NUM_REQ*WIDTH-1:0]     req_b_i,
    input  logic [NUM_REQ*OP_WIDTH-1:0]  req_op_i,
    output logic [NUM_REQ-1:0]           resp_valid_o,
    input  logic [NUM_REQ-1:0]           resp_ready_i,
    output logic [WIDTH-1:0]             resp_res_o,
    output logic                         resp_zero_o,
    output logic                         resp_err_o,
    output logic [ID_W-1:0]              resp_id_o
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              zero_q, zero_d;
    logic              err_q, err_d;
    logic [ID_W-1:0]   id_q, id_d;

    logic [ID_W-1:0]     w_grant;
    logic                w_any_valid;
    logic                w_can_accept;
    logic                w_accept;
    logic                w_consume;
    logic [ID_W-1:0]     w_grant_next;
    logic [WIDTH-1:0]    w_alu_a;
    logic [WIDTH-1:0]    w_alu_b;
    logic [OP_WIDTH-1:0] w_alu_op;
    logic [WIDTH-1:0]    w_alu_res;
    logic                w_alu_zero;
    logic                w_op_legal;

    // Pick the first valid requester, starting the scan at the round-robin pointer.
    always_comb begin
        int v_idx;
        w_grant     = '0;
        w_any_valid = 1'b0;
        v_idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = int'(rr_ptr_q) + k;
            if (v_idx >= NUM_REQ) begin
                v_idx = v_idx - NUM_REQ;
            end
            if (!w_any_valid && req_valid_i[v_idx]) begin
                w_any_valid = 1'b1;
                w_grant     = ID_W'(v_idx);
            end
        end
    end

    // A slot is free when the buffer is empty, or when its owner drains it this cycle.
    assign w_consume    = (state_q == S_FULL) && resp_ready_i[id_q];
    assign w_can_accept = (state_q == S_IDLE) || w_consume;
    assign w_accept     = !rst && w_any_valid && w_can_accept;

    // Only the granted requester ever sees ready; nothing is accepted during reset.
    always_comb begin
        req_ready_o = '0;
        if (!rst && w_any_valid) begin
            req_ready_o[w_grant] = w_can_accept;
        end
    end

    // Steer the winner's operands into the shared ALU.
    assign w_alu_a  = req_a_i[int'(w_grant)*WIDTH +: WIDTH];
    assign w_alu_b  = req_b_i[int'(w_grant)*WIDTH +: WIDTH];
    assign w_alu_op = req_op_i[int'(w_grant)*OP_WIDTH +: OP_WIDTH];

    alu #(
        .WIDTH    (WIDTH),
        .OP_WIDTH (OP_WIDTH)
    ) u_alu (
        .a_i    (w_alu_a),
        .b_i    (w_alu_b),
        .op_i   (w_alu_op),
        .res_o  (w_alu_res),
        .zero_o (w_alu_zero)
    );

    // Legal codes are the contiguous range ALU_ADD..ALU_JALR.
    assign w_op_legal = (w_alu_op <= OP_WIDTH'(ALU_JALR));

    // The pointer moves just past the winner, wrapping at NUM_REQ.
    assign w_grant_next = (int'(w_grant) == NUM_REQ - 1) ? '0 : (w_grant + ID_W'(1));

    // Next-state: accept (possibly overlapping a consume) refills the buffer;
    // a consume alone empties it. The pointer only moves on accept.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        res_d    = res_q;
        zero_d   = zero_q;
        err_d    = err_q;
        id_d     = id_q;
        if (w_accept) begin
            state_d  = S_FULL;
            rr_ptr_d = w_grant_next;
            res_d    = w_alu_res;
            zero_d   = w_alu_zero;
            err_d    = !w_op_legal;
            id_d     = w_grant;
        end else if (w_consume) begin
            state_d = S_IDLE;
        end
    end

    // State and response-buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            id_q     <= id_d;
        end
    end

    // The response valid is one-hot on the buffer owner while the buffer is full.
    always_comb begin
        resp_valid_o = '0;
        if (state_q == S_FULL) begin
            resp_valid_o[id_q] = 1'b1;
        end
    end

    assign resp_res_o  = res_q;
    assign resp_zero_o = zero_q;
    assign resp_err_o  = err_q;
    assign resp_id_o   = id_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arb
// Purpose  : Directed self-checking bench for alu_share_arb (2 requesters,
//            64-bit datapath).
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_share_arb;
    import alu_share_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int WIDTH   = 64;
    localparam int OPW     = ALU_OP_W;
    localparam int ID_W    = 1;

    logic                     clk;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ*OPW-1:0]   req_op;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [NUM_REQ-1:0]       resp_ready;
    logic [WIDTH-1:0]         resp_res;
    logic                     resp_zero;
    logic                     resp_err;
    logic [ID_W-1:0]          resp_id;

    int checks = 0;
    int errors = 0;

    alu_share_arb #(
        .NUM_REQ  (NUM_REQ),
        .WIDTH    (WIDTH),
        .OP_WIDTH (OPW),
        .ID_W     (ID_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_op_i     (req_op),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_res_o   (resp_res),
        .resp_zero_o  (resp_zero),
        .resp_err_o   (resp_err),
        .resp_id_o    (resp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [63:0] a, input logic [63:0] b,
                           input logic [OPW-1:0] op);
        req_a[idx*WIDTH +: WIDTH] = a;
        req_b[idx*WIDTH +: WIDTH] = b;
        req_op[idx*OPW +: OPW]    = op;
    endtask

    initial begin
        logic [1:0] exp_g;
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = '0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;

        // Reset held for two cycles; ready must stay low even with a request.
        tick();
        tick();
        req_valid = 2'b01;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_resp_valid", 64'(resp_valid), 64'h0);
        chk("rst_resp_res", resp_res, 64'h0);
        chk("rst_resp_zero", 64'(resp_zero), 64'h0);
        chk("rst_resp_err", 64'(resp_err), 64'h0);
        chk("rst_resp_id", 64'(resp_id), 64'h0);

        // Single op: 5 + 7.
        rst = 1'b0;
        set_req(0, 64'd5, 64'd7, ALU_ADD);
        resp_ready = 2'b01;
        #1;
        chk("single_req_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        #1;
        chk("single_resp_valid", 64'(resp_valid), 64'h1);
        chk("single_resp_res", resp_res, 64'd12);
        chk("single_resp_zero", 64'(resp_zero), 64'h0);
        chk("single_resp_err", 64'(resp_err), 64'h0);
        chk("single_resp_id", 64'(resp_id), 64'h0);
        tick();
        chk("single_drained", 64'(resp_valid), 64'h0);

        // Round-robin from a fresh pointer: grants 0,1,0,1,0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 64'd1, 64'd1, ALU_ADD);
        set_req(1, 64'd10, 64'd20, ALU_ADD);
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        #1;
        for (int i = 0; i < 5; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            chk("rr_grant", 64'(req_ready), 64'(exp_g));
            if (i > 0) begin
                chk("rr_resp_valid", 64'(resp_valid), ((i - 1) % 2 == 0) ? 64'h1 : 64'h2);
                chk("rr_resp_id", 64'(resp_id), 64'((i - 1) % 2));
                chk("rr_resp_res", resp_res, ((i - 1) % 2 == 0) ? 64'd2 : 64'd30);
            end
            tick();
        end
        req_valid = 2'b00;
        #1;
        chk("rr_last_valid", 64'(resp_valid), 64'h1);
        chk("rr_last_id", 64'(resp_id), 64'h0);
        chk("rr_last_res", resp_res, 64'd2);
        tick();
        chk("rr_drained", 64'(resp_valid), 64'h0);

        // Backpressure: 3 - 3 held while requester 1 is not ready.
        resp_ready = 2'b00;
        set_req(1, 64'd3, 64'd3, ALU_SUB);
        req_valid = 2'b10;
        #1;
        chk("bp_accept", 64'(req_ready), 64'h2);
        tick();
        set_req(0, 64'd4, 64'd2, ALU_ADD);
        req_valid = 2'b01;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_resp_valid", 64'(resp_valid), 64'h2);
            chk("bp_resp_res", resp_res, 64'h0);
            chk("bp_resp_zero", 64'(resp_zero), 64'h1);
            chk("bp_req_ready", 64'(req_ready), 64'h0);
            tick();
        end
        resp_ready = 2'b10;
        #1;
        chk("bp_release_grant", 64'(req_ready), 64'h1);
        chk("bp_release_valid", 64'(resp_valid), 64'h2);
        tick();
        req_valid  = 2'b00;
        resp_ready = 2'b01;
        #1;
        chk("bp_next_valid", 64'(resp_valid), 64'h1);
        chk("bp_next_res", resp_res, 64'd6);
        chk("bp_next_id", 64'(resp_id), 64'h0);
        tick();
        chk("bp_drained", 64'(resp_valid), 64'h0);

        // Back-to-back shifts: 1 << 0..7, one result per cycle.
        resp_ready = 2'b01;
        for (int i = 0; i < 8; i++) begin
            set_req(0, 64'd1, 64'(i), ALU_SLL);
            req_valid = 2'b01;
            #1;
            chk("b2b_req_ready", 64'(req_ready), 64'h1);
            if (i > 0) begin
                chk("b2b_resp_valid", 64'(resp_valid), 64'h1);
                chk("b2b_resp_res", resp_res, 64'd1 << (i - 1));
            end
            tick();
        end
        req_valid = 2'b00;
        #1;
        chk("b2b_last_valid", 64'(resp_valid), 64'h1);
        chk("b2b_last_res", resp_res, 64'd128);
        tick();
        chk("b2b_drained", 64'(resp_valid), 64'h0);

        // Illegal opcode followed by a legal XOR that yields zero.
        set_req(0, 64'h55, 64'h3, 4'hF);
        req_valid = 2'b01;
        #1;
        chk("ill_accept", 64'(req_ready), 64'h1);
        tick();
        set_req(0, 64'hF, 64'hF, ALU_XOR);
        #1;
        chk("ill_resp_valid", 64'(resp_valid), 64'h1);
        chk("ill_resp_err", 64'(resp_err), 64'h1);
        chk("ill_next_accept", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        #1;
        chk("xor_resp_valid", 64'(resp_valid), 64'h1);
        chk("xor_resp_err", 64'(resp_err), 64'h0);
        chk("xor_resp_zero", 64'(resp_zero), 64'h1);
        chk("xor_resp_res", resp_res, 64'h0);
        tick();
        chk("xor_drained", 64'(resp_valid), 64'h0);

        // Reset while full drops the result and returns the pointer to 0.
        resp_ready = 2'b00;
        set_req(0, 64'd9, 64'd1, ALU_ADD);
        req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b00;
        #1;
        chk("mid_full", 64'(resp_valid), 64'h1);
        rst = 1'b1;
        tick();
        set_req(1, 64'd2, 64'd2, ALU_ADD);
        req_valid = 2'b11;
        #1;
        chk("mid_rst_valid", 64'(resp_valid), 64'h0);
        chk("mid_rst_ready", 64'(req_ready), 64'h0);
        rst        = 1'b0;
        resp_ready = 2'b11;
        #1;
        chk("mid_post_grant", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        #1;
        chk("mid_post_valid", 64'(resp_valid), 64'h1);
        chk("mid_post_id", 64'(resp_id), 64'h0);
        chk("mid_post_res", resp_res, 64'd10);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
